// File: rtl/norm2_mul_arbiter_if.sv
// Requester-side operand and result handshakes of the shared norm2 multiplier.
// The master modport is the requester side and the slave modport is the arbiter side.
interface norm2_mul_arbiter_if #(
   parameter int unsigned NumReq    = 4,
   parameter int unsigned Din0Width = 39,
   parameter int unsigned Din1Width = 4,
   parameter int unsigned DoutWidth = 43
);
   logic [NumReq-1:0]           req_valid;
   logic [NumReq-1:0]           req_ready;
   logic [NumReq*Din0Width-1:0] req_din0;
   logic [NumReq*Din1Width-1:0] req_din1;
   logic [NumReq-1:0]           rsp_valid;
   logic [NumReq-1:0]           rsp_ready;
   logic [DoutWidth-1:0]        rsp_dout;
   logic                        busy;

   modport master (
      output req_valid, req_din0, req_din1, rsp_ready,
      input  req_ready, rsp_valid, rsp_dout, busy
   );

   modport slave (
      input  req_valid, req_din0, req_din1, rsp_ready,
      output req_ready, rsp_valid, rsp_dout, busy
   );
endinterface

// File: rtl/norm2_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined unsigned multiplier between NumReq requesters.
// Each result returns tagged to its issuer; a stalled last stage freezes the whole pipe.
module norm2_mul_arbiter #(
   parameter int unsigned NumReq    = 4,
   parameter int unsigned Din0Width = 39,
   parameter int unsigned Din1Width = 4,
   parameter int unsigned DoutWidth = 43,
   parameter int unsigned MulStages = 2
) (
   input logic                ap_clk,
   input logic                ap_rst_n,
   norm2_mul_arbiter_if.slave bus_io
);
   localparam int unsigned PtrW = $clog2(NumReq);
   localparam int unsigned Last = MulStages - 1;

   logic [1:0]           rst_sync_q;
   logic                 run;
   logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [MulStages-1:0] valid_q, valid_d;
   logic [PtrW-1:0]      tag_q  [MulStages];
   logic [PtrW-1:0]      tag_d  [MulStages];
   logic [DoutWidth-1:0] data_q [MulStages];
   logic [DoutWidth-1:0] data_d [MulStages];
   logic                 advance, found, accept;
   logic [PtrW-1:0]      grant, cand;
   logic [Din0Width-1:0] op_a;
   logic [Din1Width-1:0] op_b;
   logic [DoutWidth-1:0] product;

   function automatic logic [DoutWidth-1:0] mul(input logic [Din0Width-1:0] a,
                                                input logic [Din1Width-1:0] b);
      return DoutWidth'(a) * DoutWidth'(b);
   endfunction

   // Grants are held off until reset release has passed through two flops.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) rst_sync_q <= 2'b00;
      else           rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign run = rst_sync_q[1];

   always_comb begin
      found = 1'b0;
      grant = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         cand = PtrW'((32'(rr_ptr_q) + k) % NumReq);
         if (!found && bus_io.req_valid[cand]) begin
            found = 1'b1;
            grant = cand;
         end
      end
   end

   assign advance = ~valid_q[Last] | bus_io.rsp_ready[tag_q[Last]];
   assign accept  = advance & found & run;
   assign op_a    = bus_io.req_din0[32'(grant) * Din0Width +: Din0Width];
   assign op_b    = bus_io.req_din1[32'(grant) * Din1Width +: Din1Width];
   // Stage 0 keeps the raw operands packed as {B, A}; stage 1 multiplies them.
   assign product = mul(data_q[0][Din0Width-1:0], data_q[0][DoutWidth-1:Din0Width]);

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      data_d   = data_q;
      rr_ptr_d = rr_ptr_q;
      if (advance) begin
         valid_d[0] = accept;
         if (accept) begin
            tag_d[0]  = grant;
            data_d[0] = (MulStages == 1) ? mul(op_a, op_b) : {op_b, op_a};
            rr_ptr_d  = (grant == PtrW'(NumReq - 1)) ? '0 : grant + 1'b1;
         end
         for (int unsigned s = 1; s < MulStages; s++) begin
            valid_d[s] = valid_q[s-1];
            if (valid_q[s-1]) begin
               tag_d[s]  = tag_q[s-1];
               data_d[s] = (s == 1) ? product : data_q[s-1];
            end
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         valid_q  <= '0;
         rr_ptr_q <= '0;
         for (int unsigned s = 0; s < MulStages; s++) begin
            tag_q[s]  <= '0;
            data_q[s] <= '0;
         end
      end else begin
         valid_q  <= valid_d;
         rr_ptr_q <= rr_ptr_d;
         tag_q    <= tag_d;
         data_q   <= data_d;
      end
   end

   assign bus_io.req_ready = accept ? (NumReq'(1) << grant) : '0;
   assign bus_io.rsp_valid = valid_q[Last] ? (NumReq'(1) << tag_q[Last]) : '0;
   assign bus_io.rsp_dout  = data_q[Last];
   assign bus_io.busy      = |valid_q;
endmodule
